adventure_engine: RTL and testbench

ADVENTURE_ENGINE -- requirements
Module: adventure_engine

---
 rtl/adventure_engine.sv | 123 ++++++++++++
 tb/tb_adventure_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adventure_engine.sv
// adventure_engine: grid dungeon walker with sword/dragon outcome; ports CLOCK_50, Reset (sync active-low), N/E/S/W buttons -> room, sword, status, moves, tick, blocked, lcd_chars; macro ADVENTURE_LCD_TEXT_EN enables 2x16 text generation
module adventure_engine #(
  parameter int GRID_W = 3,
  parameter int GRID_H = 3,
  parameter int START_ROOM = 0,
  parameter int SWORD_ROOM = 2,
  parameter int DRAGON_ROOM = 8,
  parameter int TICK_DIV = 20,
  parameter int MOVE_W = 8
) (
  input  logic                                CLOCK_50,
  input  logic                                Reset,
  input  logic                                N,
  input  logic                                E,
  input  logic                                S,
  input  logic                                W,
  output logic [$clog2(GRID_W*GRID_H)-1:0]    room,
  output logic                                sword,
  output logic [1:0]                          status,
  output logic [MOVE_W-1:0]                   moves,
  output logic                                tick,
  output logic                                blocked,
  output logic [255:0]                        lcd_chars
);
  localparam int RW = $clog2(GRID_W*GRID_H);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [RW-1:0] GW = RW'(GRID_W);
  localparam logic [RW-1:0] GMX = RW'(GRID_W-1);
  localparam logic [RW-1:0] GMY = RW'(GRID_H-1);
  localparam logic [RW-1:0] SX = RW'(START_ROOM % GRID_W);
  localparam logic [RW-1:0] SY = RW'(START_ROOM / GRID_W);
  typedef enum logic [1:0] {ST_PLAY = 2'd0, ST_WIN = 2'd1, ST_DEAD = 2'd2} state_t;
  state_t r_status, w_status_nxt;
  logic [DW-1:0] r_div;
  logic [3:0] r_prev, r_pend, w_btn, w_rise;
  logic [RW-1:0] r_x, r_y, w_nx, w_ny, w_room, w_nroom;
  logic [MOVE_W-1:0] r_moves;
  logic r_sword, r_blocked, w_ok, w_go;
  assign w_btn = {N, E, S, W};
  assign w_rise = w_btn & ~r_prev;
  assign tick = r_div == DW'(TICK_DIV-1);
  assign w_room = r_y*GW + r_x;
  assign w_nroom = w_ny*GW + w_nx;
  assign w_go = tick && r_status == ST_PLAY && w_ok;
  // only the highest-priority pending direction is evaluated
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    w_ok = 1'b0;
    if (r_pend[3]) begin
      w_ny = r_y - 1'b1;
      w_ok = r_y != '0;
    end else if (r_pend[2]) begin
      w_nx = r_x + 1'b1;
      w_ok = r_x != GMX;
    end else if (r_pend[1]) begin
      w_ny = r_y + 1'b1;
      w_ok = r_y != GMY;
    end else if (r_pend[0]) begin
      w_nx = r_x - 1'b1;
      w_ok = r_x != '0;
    end
  end
  // sword must already be held before the dragon room is entered
  always_comb begin
    w_status_nxt = r_status;
    if (w_go && w_nroom == RW'(DRAGON_ROOM)) w_status_nxt = r_sword ? ST_WIN : ST_DEAD;
  end
  always_ff @(posedge CLOCK_50) r_status <= !Reset ? ST_PLAY : w_status_nxt;
  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      r_div <= '0;
      r_prev <= '0;
      r_pend <= '0;
      r_x <= SX;
      r_y <= SY;
      r_moves <= '0;
      r_sword <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_div <= tick ? '0 : r_div + 1'b1;
      r_prev <= w_btn;
      // edges seen in the tick cycle itself survive the clear
      r_pend <= tick ? w_rise : (r_pend | w_rise);
      r_blocked <= tick && r_status == ST_PLAY && |r_pend && !w_ok;
      if (w_go) begin
        r_x <= w_nx;
        r_y <= w_ny;
        r_moves <= r_moves + MOVE_W'(r_moves != '1);
        if (w_nroom == RW'(SWORD_ROOM)) r_sword <= 1'b1;
      end
    end
  end
  assign room = w_room;
  assign sword = r_sword;
  assign status = r_status;
  assign moves = r_moves;
  assign blocked = r_blocked;
`ifdef ADVENTURE_LCD_TEXT_EN
  localparam logic [39:0] T_SWORD = "SWORD";
  logic [255:0] r_lcd, w_lcd;
  logic [7:0] w_r8;
  logic [31:0] w_st;
  assign w_r8 = 8'(w_room);
  assign w_st = r_status == ST_WIN ? "WIN!" : r_status == ST_DEAD ? "DEAD" : "PLAY";
  // packed string literals hold the first character in the top byte
  always_comb begin
    w_lcd = {32{8'h20}};
    w_lcd[0+:8] = "R";
    w_lcd[8+:8] = "O";
    w_lcd[16+:8] = "O";
    w_lcd[24+:8] = "M";
    w_lcd[40+:8] = 8'h30 + w_r8 / 8'd10;
    w_lcd[48+:8] = 8'h30 + w_r8 % 8'd10;
    for (int c = 0; c < 4; c++) w_lcd[(16+c)*8 +: 8] = w_st[(3-c)*8 +: 8];
    for (int c = 0; c < 5; c++) w_lcd[(21+c)*8 +: 8] = r_sword ? T_SWORD[(4-c)*8 +: 8] : 8'h20;
  end
  always_ff @(posedge CLOCK_50) r_lcd <= !Reset ? {32{8'h20}} : w_lcd;
  assign lcd_chars = r_lcd;
`else
  assign lcd_chars = {32{8'h20}};
`endif
endmodule

// File: tb/tb_adventure_engine.sv
// tb_adventure_engine: table-driven and directed checks of adventure_engine with default parameters
module tb_adventure_engine;
  localparam int TD = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [3:0] room;
  logic sword, tick, blocked;
  logic [1:0] status;
  logic [7:0] moves;
  logic [255:0] lcd;
  int checks = 0, failures = 0;
  adventure_engine dut (
    .CLOCK_50(clk), .Reset(rst_n), .N(btn[3]), .E(btn[2]), .S(btn[1]), .W(btn[0]),
    .room(room), .sword(sword), .status(status), .moves(moves),
    .tick(tick), .blocked(blocked), .lcd_chars(lcd)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] btn;
    int room;
    int sword;
    int status;
    int moves;
    int blk;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic chk_lcd(input string nm, input logic [255:0] exp);
    checks++;
    if (lcd !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, lcd, exp);
    end
  endtask
  task automatic rst_dut();
    @(negedge clk);
    rst_n = 1'b0;
    btn = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_tick();
    bit ok = 0;
    for (int i = 0; i < 3*TD; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tick_timeout actual=0 required=1");
    end
  endtask
  task automatic step(input logic [3:0] b);
    btn = b;
    @(negedge clk);
    btn = 4'b0;
    wait_tick();
    @(negedge clk);
  endtask
  task automatic chk_state(input string nm, input int r, input int sw, input int st, input int m, input int bk);
    chk({nm, "_room"}, room, r);
    chk({nm, "_sword"}, sword, sw);
    chk({nm, "_status"}, status, st);
    chk({nm, "_moves"}, moves, m);
    chk({nm, "_blocked"}, blocked, bk);
  endtask
  initial begin
    logic [255:0] exp_lcd;
    string r0, r1;
    int n;
    v[0]  = '{1'b1, 4'b0100, 1, 0, 0, 1, 0};
    v[1]  = '{1'b0, 4'b0100, 2, 1, 0, 2, 0};
    v[2]  = '{1'b0, 4'b0010, 5, 1, 0, 3, 0};
    v[3]  = '{1'b0, 4'b0010, 8, 1, 1, 4, 0};
    v[4]  = '{1'b0, 4'b0001, 8, 1, 1, 4, 0};
    v[5]  = '{1'b1, 4'b1000, 0, 0, 0, 0, 1};
    v[6]  = '{1'b0, 4'b0010, 3, 0, 0, 1, 0};
    v[7]  = '{1'b0, 4'b0010, 6, 0, 0, 2, 0};
    v[8]  = '{1'b0, 4'b0100, 7, 0, 0, 3, 0};
    v[9]  = '{1'b0, 4'b0100, 8, 0, 2, 4, 0};
    v[10] = '{1'b0, 4'b1000, 8, 0, 2, 4, 0};
    v[11] = '{1'b1, 4'b0100, 1, 0, 0, 1, 0};
    v[12] = '{1'b0, 4'b0010, 4, 0, 0, 2, 0};
    v[13] = '{1'b0, 4'b1001, 1, 0, 0, 3, 0};
    v[14] = '{1'b0, 4'b0000, 1, 0, 0, 3, 0};
    v[15] = '{1'b0, 4'b0001, 0, 0, 0, 4, 0};
    v[16] = '{1'b0, 4'b0001, 0, 0, 0, 4, 1};
    rst_dut();
    chk_state("reset", 0, 0, 0, 0, 0);
    chk("reset_tick", tick, 0);
    chk_lcd("reset_lcd", {32{8'h20}});
    n = 0;
    while (!tick && n < 3*TD) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_edges", n, TD-1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3*TD);
    chk("tick_period", n, TD);
    for (int i = 0; i < 17; i++) begin
      if (v[i].rst) rst_dut();
      step(v[i].btn);
      chk_state($sformatf("v%0d", i), v[i].room, v[i].sword, v[i].status, v[i].moves, v[i].blk);
    end
    rst_dut();
    step(4'b0100);
    step(4'b0100);
    chk_state("pre_rst", 2, 1, 0, 2, 0);
    btn = 4'b0010;
    @(negedge clk);
    btn = 4'b0;
    wait_tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk_state("rst_in_tick", 0, 0, 0, 0, 0);
    chk("rst_in_tick_tick", tick, 0);
    rst_n = 1'b1;
    rst_dut();
    btn = 4'b0100;
    wait_tick();
    @(negedge clk);
    chk_state("held1", 1, 0, 0, 1, 0);
    wait_tick();
    @(negedge clk);
    chk_state("held2", 1, 0, 0, 1, 0);
    btn = 4'b0;
    wait_tick();
    btn = 4'b0010;
    @(negedge clk);
    btn = 4'b0;
    chk_state("edge_in_tick_a", 1, 0, 0, 1, 0);
    wait_tick();
    @(negedge clk);
    chk_state("edge_in_tick_b", 4, 0, 0, 2, 0);
    rst_dut();
    step(4'b0100);
    step(4'b0100);
    step(4'b0010);
    step(4'b0010);
    @(negedge clk);
    chk_state("win_path", 8, 1, 1, 4, 0);
    exp_lcd = {32{8'h20}};
`ifdef ADVENTURE_LCD_TEXT_EN
    r0 = "ROOM 08";
    r1 = "WIN! SWORD";
    for (int c = 0; c < r0.len(); c++) exp_lcd[c*8 +: 8] = r0[c];
    for (int c = 0; c < r1.len(); c++) exp_lcd[(16+c)*8 +: 8] = r1[c];
`endif
    chk_lcd("win_lcd", exp_lcd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
